alu_shift_seq: RTL and testbench
================================

Name: alu_shift_seq

Overview:
- Multi-cycle shift/rotate sequencer. It is the initiator for the datapath ALU, which is a combinational responder.
- Accepts one shift/rotate request of 0..7 bit positions over a valid/ready handshake.
- Breaks the request into the ALU's native 1-bit and 2-bit shift commands, feeds each ALU result back as the next operand, and returns the final byte over a second valid/ready handshake.
- Sits between the control unit and the ALU operand muxes. Multi-bit shifts never need more than one instruction.

Parameters:
- CMD_SHIFT, 3'b001, ALU command code for shift; ALU inB = {5'b0, dir, mode, imm}.
- CMD_IDLE, 3'b000, command driven when not issuing.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  sequencer can accept a request.
- req_op  in  2  00 LSL, 01 LSR, 10 ROL, 11 ROR.
- req_amt  in  3  shift amount, 0..7.
- req_data  in  8  operand.
- alu_cmd  out  3  to ALU alu_cmd.
- alu_inA  out  8  to ALU inA.
- alu_inB  out  8  to ALU inB.
- alu_rslt  in  8  from ALU rslt (combinational, same cycle).
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer accepts result.
- rsp_data  out  8  shifted/rotated result.
- rsp_zero  out  1  rsp_data == 0.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high.
- Reset state: state=IDLE, acc=0, rem=0, op=0.
  - rsp_valid=0, rsp_data=0, rsp_zero=1.
  - req_ready=0 while reset is high.
  - alu_cmd=CMD_IDLE, alu_inA=0, alu_inB=0.
- State machine has three states: IDLE, ISSUE, DONE.
- IDLE:
  - req_ready=1.
  - On req_valid at a clock edge: acc<=req_data, rem<=req_amt, op<=req_op.
  - Next state is DONE if req_amt==0, else ISSUE.
- ISSUE (req_ready=0):
  - step = 2 if rem>=2, else 1.
  - alu_cmd=CMD_SHIFT, alu_inA=acc.
  - alu_inB = {5'b0, op[0], op[1], step==2}, where dir 1 = right and mode 1 = rotate.
  - At the clock edge: acc<=alu_rslt, rem<=rem-step.
  - Go to DONE when rem-step==0; otherwise stay in ISSUE.
- DONE:
  - rsp_valid=1, rsp_data=acc, rsp_zero=(acc==0).
  - Hold all three until rsp_ready is seen at an edge, then go to IDLE.
- Outside ISSUE, alu_cmd/inA/inB stay at their reset values. ALU outputs are ignored.
- Latency from request accept edge to rsp_valid: ceil(amt/2) cycles.
  - amt=0 gives rsp_valid on the cycle immediately after accept.
  - No ALU ops are issued for amt=0.
- Throughput: at least 1 idle cycle between responses. There is no accept in the same cycle as the response handshake.
- Boundary conditions:
  - req_valid while not IDLE: ignored. The request is not latched and req_ready stays 0.
  - Request fields after accept: changes have no effect.
  - rsp_ready held low: rsp_data and rsp_zero stay stable indefinitely.
  - Reset mid-ISSUE or mid-DONE: abort. All state returns to reset values next edge and no response is produced.
- All state is registered. ALU drive signals are combinational decodes of state/acc/rem/op; there are no combinational paths from alu_rslt to any output.

Decomposition:
- Shared package alu_pkg holds:
  - ALU command codes: ADD_INC, SHIFT, XOR, BNE, LOAD, STORE, LOADREG, CONCAT.
  - Shift inB field positions: dir bit 2, mode bit 1, imm bit 0.
  - Request op enum: LSL, LSR, ROL, ROR.
  - Sequencer state enum.
- The ALU module is not the deliverable and is not a sub-module of this block. The system top instantiates it, and the bench uses the real ALU.
- The block is a single module with no sub-modules.

Test Plan:
- LSL 0xB5 by 3: ISSUE drives inB=0x01, then inB=0x00; rsp_valid 2 cycles after accept, rsp_data=0xA8, rsp_zero=0.
- ROR 0x81 by 7: inB sequence 0x07, 0x07, 0x07, 0x06; rsp_data=0x03 after 4 cycles.
- LSR 0xF0 by 0: alu_cmd stays CMD_IDLE; rsp_valid on the next cycle with rsp_data=0xF0.
- LSR 0x0F by 4: inB 0x05, 0x05; rsp_data=0x00, rsp_zero=1.
- Backpressure on ROL 0x12 by 1 (inB=0x02):
  - Response is 0x24.
  - Hold rsp_ready=0 for 5 cycles while pulsing req_valid with new data: rsp_data stays 0x24, req_ready stays 0, the new request is not accepted.
  - After rsp_ready=1: IDLE and req_ready=1 on the following cycle.
- Reset mid-ISSUE: ROL 0x12 by 6, assert reset after the first ISSUE cycle.
  - Next cycle: rsp_valid=0, alu_cmd=CMD_IDLE, acc=0.
  - After deassert: req_ready=1 and no stray response appears.

Source files
------------

// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the datapath ALU and the blocks that drive it.
//   - ALU command codes (3-bit alu_cmd encoding)
//   - Field positions of the shift control byte carried on ALU inB
//   - Shift/rotate request opcodes seen by the shift sequencer
//   - Shift sequencer state encoding
//   - Helper that packs a shift control byte
// -----------------------------------------------------------------------------
package alu_pkg;

  localparam int DATA_W = 8;
  localparam int AMT_W  = 3;

  // ALU command codes
  typedef enum logic [2:0] {
    ALU_ADD_INC = 3'b000,
    ALU_SHIFT   = 3'b001,
    ALU_XOR     = 3'b010,
    ALU_BNE     = 3'b011,
    ALU_LOAD    = 3'b100,
    ALU_STORE   = 3'b101,
    ALU_LOADREG = 3'b110,
    ALU_CONCAT  = 3'b111
  } alu_cmd_e;

  // Shift control byte on inB: {5'b0, dir, mode, imm}
  //   dir  : 1 = right, 0 = left
  //   mode : 1 = rotate, 0 = logical shift
  //   imm  : 1 = shift by two positions, 0 = by one
  localparam int SHB_DIR  = 2;
  localparam int SHB_MODE = 1;
  localparam int SHB_IMM  = 0;

  // Request opcodes; bit 0 selects direction, bit 1 selects rotate.
  typedef enum logic [1:0] {
    OP_LSL = 2'b00,
    OP_LSR = 2'b01,
    OP_ROL = 2'b10,
    OP_ROR = 2'b11
  } shift_op_e;

  // Sequencer states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_DONE  = 2'b10
  } seq_state_e;

  // Build the ALU shift control byte for one native step.
  function automatic logic [DATA_W-1:0] shift_inb(input shift_op_e op,
                                                  input logic      two);
    logic [DATA_W-1:0] b;
    b           = '0;
    b[SHB_DIR]  = op[0];
    b[SHB_MODE] = op[1];
    b[SHB_IMM]  = two;
    return b;
  endfunction

endpackage

// File: rtl/alu_shift_seq.sv
// -----------------------------------------------------------------------------
// alu_shift_seq
// Multi-cycle shift/rotate sequencer. Accepts a 0..7 position shift or rotate
// of one byte, walks it through the ALU's native 1- and 2-bit shift commands
// (feeding each ALU result back as the next operand) and returns the byte.
//
// Ports
//   clk, reset           : clock, synchronous active-high reset
//   req_valid/req_ready  : request handshake
//   req_op               : 00 LSL, 01 LSR, 10 ROL, 11 ROR
//   req_amt              : shift amount 0..7
//   req_data             : operand byte
//   alu_cmd/inA/inB      : drive to the combinational ALU
//   alu_rslt             : ALU result (same cycle)
//   rsp_valid/rsp_ready  : response handshake
//   rsp_data, rsp_zero   : result byte and its zero flag
// -----------------------------------------------------------------------------
module alu_shift_seq
  import alu_pkg::*;
#(
  parameter logic [2:0] CMD_SHIFT = 3'b001,
  parameter logic [2:0] CMD_IDLE  = 3'b000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [AMT_W-1:0]  req_amt,
  input  logic [DATA_W-1:0] req_data,
  output logic [2:0]        alu_cmd,
  output logic [DATA_W-1:0] alu_inA,
  output logic [DATA_W-1:0] alu_inB,
  input  logic [DATA_W-1:0] alu_rslt,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_zero
);

  seq_state_e        state;
  logic [DATA_W-1:0] acc;
  logic [AMT_W-1:0]  rem;
  shift_op_e         op;

  logic              step_two;
  logic [AMT_W-1:0]  rem_next;

  // Take the 2-bit native step whenever at least two positions remain, so
  // an odd amount finishes with a single 1-bit step.
  always_comb begin
    step_two = (rem >= AMT_W'(2));
    rem_next = step_two ? (rem - AMT_W'(2)) : (rem - AMT_W'(1));
  end

  // ALU drive: quiet (reset values) outside ISSUE so the ALU sees no spurious
  // shift commands.
  always_comb begin
    alu_cmd = CMD_IDLE;
    alu_inA = '0;
    alu_inB = '0;
    if (state == ST_ISSUE) begin
      alu_cmd = CMD_SHIFT;
      alu_inA = acc;
      alu_inB = shift_inb(op, step_two);
    end
  end

  // Reset gates readiness so nothing is accepted while reset is held.
  assign req_ready = (state == ST_IDLE) && !reset;

  // Control FSM with registered response outputs. The response byte is
  // captured on the edge that enters DONE, so alu_rslt never reaches an
  // output combinationally.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      acc       <= '0;
      rem       <= '0;
      op        <= OP_LSL;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_zero  <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            acc <= req_data;
            rem <= req_amt;
            op  <= shift_op_e'(req_op);
            if (req_amt == '0) begin
              state     <= ST_DONE;
              rsp_valid <= 1'b1;
              rsp_data  <= req_data;
              rsp_zero  <= (req_data == '0);
            end else begin
              state <= ST_ISSUE;
            end
          end
        end

        ST_ISSUE: begin
          acc <= alu_rslt;
          rem <= rem_next;
          if (rem_next == '0) begin
            state     <= ST_DONE;
            rsp_valid <= 1'b1;
            rsp_data  <= alu_rslt;
            rsp_zero  <= (alu_rslt == '0);
          end
        end

        ST_DONE: begin
          // Response fields hold until the consumer takes them; IDLE follows
          // so there is always a gap cycle before the next accept.
          if (rsp_ready) begin
            state     <= ST_IDLE;
            rsp_valid <= 1'b0;
          end
        end

        default: begin
          state     <= ST_IDLE;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_shift_seq.sv
module tb_alu_shift_seq;
  import alu_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [1:0] req_op = 2'b00;
  logic [2:0] req_amt = 3'd0;
  logic [7:0] req_data = 8'h00;
  logic [2:0] alu_cmd;
  logic [7:0] alu_inA, alu_inB, alu_rslt;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic [7:0] rsp_data;
  logic       rsp_zero;

  int n_cmp = 0;
  int n_fail = 0;
  int bp_mode = 0;   // 0: always ready, 1: random, 2: held low

  typedef struct {
    logic [7:0] data;
    logic       zero;
  } rsp_t;

  typedef struct {
    logic [7:0] ina;
    logic [7:0] inb;
  } alu_t;

  rsp_t rsp_q[$];
  alu_t alu_q[$];

  alu_shift_seq dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_amt(req_amt), .req_data(req_data),
    .alu_cmd(alu_cmd), .alu_inA(alu_inA), .alu_inB(alu_inB),
    .alu_rslt(alu_rslt),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_zero(rsp_zero)
  );

  always #5 clk = ~clk;

  // Whole-byte reference: shift/rotate by any amount with plain arithmetic.
  function automatic logic [7:0] ref_shift(input logic [1:0] op, input int amt,
                                           input logic [7:0] d);
    logic [15:0] w;
    case (op)
      2'b00: begin w = {8'h00, d} << amt; return w[7:0]; end
      2'b01: return d >> amt;
      2'b10: begin w = {d, d} << amt; return w[15:8]; end
      default: begin w = {d, d} >> amt; return w[7:0]; end
    endcase
  endfunction

  // Behavioural ALU: shift command decoded from inB; other commands return
  // junk the sequencer must ignore.
  always_comb begin
    alu_rslt = alu_inA ^ 8'h5A;
    if (alu_cmd == 3'b001)
      alu_rslt = ref_shift({alu_inB[1], alu_inB[2]}, alu_inB[0] ? 2 : 1, alu_inA);
  end

  function automatic void chk(input string nm, input logic [31:0] act,
                              input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  // Consumer backpressure
  always @(posedge clk) begin
    #1;
    case (bp_mode)
      0: rsp_ready = 1'b1;
      1: rsp_ready = 1'($urandom_range(0, 1));
      default: rsp_ready = 1'b0;
    endcase
  end

  // Monitor: ALU commands and responses against the scoreboard queues.
  logic       hold_pending = 1'b0;
  logic [7:0] held_data;
  logic       held_zero;
  always @(negedge clk) begin
    if (reset) begin
      hold_pending = 1'b0;
    end else begin
      if (alu_cmd == 3'b001) begin
        if (alu_q.size() == 0) begin
          chk("unexpected_alu_shift", {alu_inA, alu_inB}, 0);
        end else begin
          alu_t e;
          e = alu_q.pop_front();
          chk("alu_inA", alu_inA, e.ina);
          chk("alu_inB", alu_inB, e.inb);
        end
      end else begin
        chk("alu_quiet", {alu_cmd, alu_inA, alu_inB}, 0);
      end

      if (hold_pending) begin
        chk("hold_data", rsp_data, held_data);
        chk("hold_zero", rsp_zero, held_zero);
        chk("hold_valid", rsp_valid, 1);
      end
      hold_pending = rsp_valid && !rsp_ready;
      held_data = rsp_data;
      held_zero = rsp_zero;

      if (rsp_valid && rsp_ready) begin
        if (rsp_q.size() == 0) begin
          chk("unexpected_rsp", rsp_data, 9'h1FF);
        end else begin
          rsp_t r;
          r = rsp_q.pop_front();
          chk("rsp_data", rsp_data, r.data);
          chk("rsp_zero", rsp_zero, r.zero);
        end
      end
    end
  end

  // Issue one request; on accept, push the expected ALU steps and response.
  task automatic send(input logic [1:0] op, input logic [2:0] amt,
                      input logic [7:0] d);
    bit ok = 0;
    bit rr;
    int done_pos = 0;
    int left;
    int st;
    rsp_t r;
    alu_t a;
    req_valid = 1'b1; req_op = op; req_amt = amt; req_data = d;
    for (int t = 0; t < 200 && !ok; t++) begin
      @(negedge clk); rr = req_ready;
      @(posedge clk); if (rr) ok = 1;
    end
    if (ok) begin
      r.data = ref_shift(op, int'(amt), d);
      r.zero = (r.data == 8'h00);
      rsp_q.push_back(r);
      left = int'(amt);
      while (left > 0) begin
        st = (left >= 2) ? 2 : 1;
        a.ina = ref_shift(op, done_pos, d);
        // dir = right-going ops, mode = rotates, imm = two-position step
        a.inb = {5'b0, (op == 2'b01 || op == 2'b11), (op == 2'b10 || op == 2'b11), st == 2};
        alu_q.push_back(a);
        done_pos += st;
        left -= st;
      end
    end else begin
      chk("accept_timeout", 0, 1);
    end
    #1;
    req_valid = 1'b0;
    req_op = 2'($urandom); req_amt = 3'($urandom); req_data = 8'($urandom);
  endtask

  // Edges from accept until rsp_valid is visible.
  task automatic check_latency(input string nm, input int exp);
    int n = 0;
    @(negedge clk);
    while (!rsp_valid && n < 50) begin
      @(posedge clk); n++;
      @(negedge clk);
    end
    chk(nm, n, exp);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_zero", rsp_zero, 1);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_alu", {alu_cmd, alu_inA, alu_inB}, 0);
    @(posedge clk); #1 reset = 1'b0;
    bp_mode = 0;
    idle(2);

    // Directed cases with latency
    send(2'b00, 3'd3, 8'hB5); check_latency("lat_lsl3", 2); idle(2);
    send(2'b11, 3'd7, 8'h81); check_latency("lat_ror7", 4); idle(2);
    send(2'b01, 3'd0, 8'hF0); check_latency("lat_lsr0", 0); idle(2);
    send(2'b01, 3'd4, 8'h0F); check_latency("lat_lsr4", 2); idle(2);

    // Backpressure: ROL 0x12 by 1 held, new requests must be ignored
    bp_mode = 2;
    idle(1);
    send(2'b10, 3'd1, 8'h12); check_latency("lat_rol1", 1);
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      req_valid = 1'b1; req_data = 8'($urandom); req_amt = 3'($urandom);
      @(negedge clk);
      chk("bp_req_ready", req_ready, 0);
      chk("bp_rsp_data", rsp_data, 8'h24);
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    bp_mode = 0;
    begin
      int n = 0;
      @(negedge clk);
      while (rsp_valid && n < 20) begin @(negedge clk); n++; end
      chk("bp_release_ready", req_ready, 1);
      chk("bp_release_valid", rsp_valid, 0);
    end
    idle(2);

    // Reset mid-ISSUE
    send(2'b10, 3'd6, 8'h12);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1;
    rsp_q.delete(); alu_q.delete();
    @(negedge clk);
    chk("abort_rsp_valid", rsp_valid, 0);
    chk("abort_alu_cmd", alu_cmd, 0);
    chk("abort_alu_inA", alu_inA, 0);
    chk("abort_acc", dut.acc, 0);
    chk("abort_req_ready", req_ready, 0);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("post_abort_ready", req_ready, 1);
    idle(10);

    // Randomized traffic with random backpressure
    bp_mode = 1;
    for (int i = 0; i < 300; i++) begin
      send(2'($urandom), 3'($urandom), 8'($urandom));
      idle($urandom_range(0, 3));
    end
    bp_mode = 0;
    begin
      int n = 0;
      while ((rsp_q.size() != 0 || alu_q.size() != 0) && n < 100) begin
        @(posedge clk); n++;
      end
      idle(2);
      chk("drain_rsp_q", rsp_q.size(), 0);
      chk("drain_alu_q", alu_q.size(), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
